// File: rtl/isa_camac_cycle_ctrl.sv
// ISA I/O cycle controller for the Sm2201 ISA-CAMAC board: port-window decode, wait-state
// generation, back-end register strobes and maskable CAMAC request interrupt.
module isa_camac_cycle_ctrl #(
   parameter logic [9:0]  BASE_ADDR   = 10'h300,
   parameter int unsigned REG_AW      = 3,
   parameter int unsigned N_CH        = 4,
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned TIMEOUT     = 32,
   parameter int unsigned IRQ_SEL     = 0
) (
   input  logic              isa_clk,
   input  logic              isa_reset,
   input  logic              isa_ior,
   input  logic              isa_iow,
   input  logic              isa_aen,
   input  logic [9:0]        isa_addr,
   input  logic [7:0]        isa_data_in,
   output logic [7:0]        isa_data_out,
   output logic              isa_data_oe,
   output logic              isa_chrdy,
   output logic [7:0]        isa_irq,
   output logic [REG_AW-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_rd,
   output logic              reg_wr,
   input  logic [7:0]        reg_rdata,
   input  logic              reg_ack,
   input  logic [N_CH-1:0]   cb_prr
);
   localparam int unsigned       CW       = $clog2(TIMEOUT + 1);
   localparam logic [REG_AW-1:0] PEND_OFS = REG_AW'((1 << REG_AW) - 2);
   localparam logic [REG_AW-1:0] MASK_OFS = REG_AW'((1 << REG_AW) - 1);
   localparam logic [CW-1:0]     WS_LAST  = CW'(WAIT_STATES - 1);
   localparam logic [CW-1:0]     TO_LAST  = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t            state_q, state_n;
   logic              armed_q, ior_q, iow_q;
   logic [N_CH-1:0]   prr_q;
   logic [CW-1:0]     cnt_q, cnt_n;
   logic              is_rd_q, is_rd_n, is_loc_q, is_loc_n, ack_q, ack_n;
   logic [7:0]        rdata_q, rdata_n;
   logic [N_CH-1:0]   mask_q, mask_n, pend_q, pend_n;
   logic              irq_q;
   logic              chrdy_q, chrdy_n, oe_q, oe_n;
   logic [7:0]        dout_q, dout_n, wdata_q, wdata_n;
   logic [REG_AW-1:0] addr_q, addr_n;
   logic              rd_q, rd_n, wr_q, wr_n;

   logic              hit, ior_fall, iow_fall, start, acked, done, loc_ofs;
   logic [N_CH-1:0]   prr_fall;
   logic [7:0]        loc_val;

   // Edges are suppressed for one cycle after reset so a line held low through reset never fires.
   assign hit      = !isa_aen && (isa_addr[9:REG_AW] == BASE_ADDR[9:REG_AW]);
   assign ior_fall = armed_q && ior_q && !isa_ior;
   assign iow_fall = armed_q && iow_q && !isa_iow;
   assign start    = hit && (ior_fall ^ iow_fall);
   assign prr_fall = armed_q ? (prr_q & ~cb_prr) : '0;
   assign loc_ofs  = (isa_addr[REG_AW-1:0] == PEND_OFS) || (isa_addr[REG_AW-1:0] == MASK_OFS);
   assign loc_val  = (addr_q == MASK_OFS) ? 8'(mask_q) : 8'(pend_q);
   assign acked    = is_loc_q || ack_q || reg_ack;
   assign done     = (cnt_q >= WS_LAST) && (acked || (cnt_q >= TO_LAST));

   // Next-state and next-output logic
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      is_rd_n  = is_rd_q;
      is_loc_n = is_loc_q;
      ack_n    = ack_q;
      rdata_n  = rdata_q;
      mask_n   = mask_q;
      pend_n   = pend_q;
      chrdy_n  = chrdy_q;
      oe_n     = oe_q;
      dout_n   = dout_q;
      wdata_n  = wdata_q;
      addr_n   = addr_q;
      rd_n     = 1'b0;
      wr_n     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_n  = S_WAIT;
               addr_n   = isa_addr[REG_AW-1:0];
               is_rd_n  = ior_fall;
               is_loc_n = loc_ofs;
               if (iow_fall) wdata_n = isa_data_in;
               chrdy_n  = 1'b0;
               cnt_n    = '0;
               ack_n    = 1'b0;
               rd_n     = ior_fall && !loc_ofs;
               wr_n     = iow_fall && !loc_ofs;
            end
         end
         S_WAIT: begin
            if (reg_ack && !ack_q) begin
               ack_n   = 1'b1;
               rdata_n = reg_rdata;
            end
            if (done) begin
               state_n = S_HOLD;
               chrdy_n = 1'b1;
               oe_n    = is_rd_q;
               if (is_loc_q)     dout_n = loc_val;
               else if (ack_q)   dout_n = rdata_q;
               else if (reg_ack) dout_n = reg_rdata;
               else              dout_n = 8'hFF;
               if (is_loc_q && !is_rd_q) begin
                  if (addr_q == MASK_OFS) mask_n = wdata_q[N_CH-1:0];
                  else                    pend_n = pend_q & ~wdata_q[N_CH-1:0];
               end
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         S_HOLD: begin
            if (is_rd_q ? isa_ior : isa_iow) begin
               oe_n    = 1'b0;
               state_n = S_IDLE;
            end else begin
               oe_n = is_rd_q;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // A request edge in the same cycle as a clear keeps its bit set.
      pend_n = pend_n | prr_fall;
   end

   always_ff @(posedge isa_clk) begin
      if (isa_reset) begin
         state_q  <= S_IDLE;
         armed_q  <= 1'b0;
         ior_q    <= 1'b1;
         iow_q    <= 1'b1;
         prr_q    <= '1;
         cnt_q    <= '0;
         is_rd_q  <= 1'b0;
         is_loc_q <= 1'b0;
         ack_q    <= 1'b0;
         rdata_q  <= '0;
         mask_q   <= '0;
         pend_q   <= '0;
         irq_q    <= 1'b0;
         chrdy_q  <= 1'b1;
         oe_q     <= 1'b0;
         dout_q   <= '0;
         wdata_q  <= '0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_n;
         armed_q  <= 1'b1;
         ior_q    <= isa_ior;
         iow_q    <= isa_iow;
         prr_q    <= cb_prr;
         cnt_q    <= cnt_n;
         is_rd_q  <= is_rd_n;
         is_loc_q <= is_loc_n;
         ack_q    <= ack_n;
         rdata_q  <= rdata_n;
         mask_q   <= mask_n;
         pend_q   <= pend_n;
         irq_q    <= |(pend_q & mask_q);
         chrdy_q  <= chrdy_n;
         oe_q     <= oe_n;
         dout_q   <= dout_n;
         wdata_q  <= wdata_n;
         addr_q   <= addr_n;
         rd_q     <= rd_n;
         wr_q     <= wr_n;
      end
   end

   assign isa_data_out = dout_q;
   assign isa_data_oe  = oe_q;
   assign isa_chrdy    = chrdy_q;
   assign isa_irq      = 8'(irq_q) << IRQ_SEL;
   assign reg_addr     = addr_q;
   assign reg_wdata    = wdata_q;
   assign reg_rd       = rd_q;
   assign reg_wr       = wr_q;
endmodule
